onchip_mem_arbiter: RTL and testbench

- Two-master arbiter that shares one single-port on-chip RAM slave (2048 x 32, byte-enabled, read latency 1) between master A and master B.
- Each master sees an Avalon-MM pipelined slave port with waitrequest and readdatavalid.
- The block drives the RAM's address/byteenable/chipselect/write/writedata/clken and routes readdata back to the correct master.
- Sits between the interconnect masters (e.g. CPU data master and a DMA) and the RAM instance.

---
 rtl/onchip_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port 2048x32 on-chip RAM with read latency 1.
// The grant is combinational from the two requests and a small amount of state:
// the round-robin pointer, or the starvation counter in fixed-priority mode.
// Read data is steered back to the master that issued the read.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int RR           = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {MST_A = 1'b0, MST_B = 1'b1} mst_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic       req_a, req_b;
  logic       gnt_a, gnt_b;
  logic       rd_acc;
  mst_e       last_grant_q, last_grant_d;
  mst_e       rd_id_q, rd_id_d;
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] starve_q, starve_d;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // Grant selection; nothing is granted while reset is high.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset) begin
      if (req_a && req_b) begin
        if (RR != 0) begin
          if (last_grant_q == MST_B) gnt_a = 1'b1;
          else                       gnt_b = 1'b1;
        end else begin
          if (starve_q == STARVE_LIM) gnt_b = 1'b1;
          else                        gnt_a = 1'b1;
        end
      end else if (req_a) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  // A requester that is not granted waits; an idle master sees waitrequest low.
  assign a_waitrequest = reset | (req_a & ~gnt_a);
  assign b_waitrequest = reset | (req_b & ~gnt_b);

  // RAM drive muxed from the granted master; zeros when nobody is granted.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (gnt_a) begin
      mem_address    = a_address;
      mem_byteenable = a_byteenable;
      mem_writedata  = a_writedata;
      mem_write      = a_write;
    end else if (gnt_b) begin
      mem_address    = b_address;
      mem_byteenable = b_byteenable;
      mem_writedata  = b_writedata;
      mem_write      = b_write;
    end
  end

  assign mem_chipselect = gnt_a | gnt_b;
  assign mem_clken      = ~reset;

  // A read with write also high is a write, so it never produces a return beat.
  assign rd_acc = (gnt_a & a_read & ~a_write) | (gnt_b & b_read & ~b_write);

  // Next-state for the read-return tracker, round-robin pointer and starvation counter.
  always_comb begin
    rd_pend_d    = rd_acc;
    rd_id_d      = rd_id_q;
    last_grant_d = last_grant_q;
    starve_d     = starve_q;
    if (rd_acc) rd_id_d = gnt_b ? MST_B : MST_A;
    if (gnt_a)      last_grant_d = MST_A;
    else if (gnt_b) last_grant_d = MST_B;
    if (RR != 0 || !req_b || gnt_b) starve_d = '0;
    else if (starve_q != 8'hFF)     starve_d = starve_q + 8'd1;
  end

  // State registers; last_grant resets to B so A wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q    <= 1'b0;
      rd_id_q      <= MST_A;
      last_grant_q <= MST_B;
      starve_q     <= '0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      rd_id_q      <= rd_id_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
    end
  end

  assign a_readdatavalid = rd_pend_q & (rd_id_q == MST_A) & ~reset;
  assign b_readdatavalid = rd_pend_q & (rd_id_q == MST_B) & ~reset;
  assign a_readdata      = a_readdatavalid ? mem_readdata : '0;
  assign b_readdata      = b_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a round-robin instance and a fixed-priority
// instance (STARVE_LIMIT = 3) share the same master stimulus, each with its own RAM.
module tb_onchip_mem_arbiter;

  localparam logic [1:0] GN = 2'b00, GA = 2'b01, GB = 2'b10;

  typedef struct packed {
    logic        m;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] a_address, b_address;
  logic [3:0]  a_byteenable, b_byteenable;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata;

  logic [1:0]  a_wait, b_wait, a_rdv, b_rdv, m_cs, m_we, m_ck;
  logic [31:0] a_rd [2];
  logic [31:0] b_rd [2];
  logic [10:0] m_addr [2];
  logic [3:0]  m_be [2];
  logic [31:0] m_wd [2];
  logic [31:0] m_rd [2];

  logic [31:0] shadow [2][2048];
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.RR(1), .STARVE_LIMIT(8)) u_rr (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_wait[0]), .a_readdata(a_rd[0]), .a_readdatavalid(a_rdv[0]),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_wait[0]), .b_readdata(b_rd[0]), .b_readdatavalid(b_rdv[0]),
    .mem_address(m_addr[0]), .mem_byteenable(m_be[0]), .mem_chipselect(m_cs[0]), .mem_write(m_we[0]),
    .mem_writedata(m_wd[0]), .mem_clken(m_ck[0]), .mem_readdata(m_rd[0])
  );

  onchip_mem_arbiter #(.RR(0), .STARVE_LIMIT(3)) u_fp (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_wait[1]), .a_readdata(a_rd[1]), .a_readdatavalid(a_rdv[1]),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_wait[1]), .b_readdata(b_rd[1]), .b_readdatavalid(b_rdv[1]),
    .mem_address(m_addr[1]), .mem_byteenable(m_be[1]), .mem_chipselect(m_cs[1]), .mem_write(m_we[1]),
    .mem_writedata(m_wd[1]), .mem_clken(m_ck[1]), .mem_readdata(m_rd[1])
  );

  // Behavioural RAM per instance: byte-enabled write, registered read.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [31:0] ram [2048];
    initial begin
      for (int i = 0; i < 2048; i++) ram[i] = '0;
      m_rd[g] = '0;
    end
    always @(posedge clk) begin
      if (m_ck[g] && m_cs[g]) begin
        if (m_we[g]) begin
          for (int i = 0; i < 4; i++)
            if (m_be[g][i]) ram[m_addr[g]][8*i +: 8] <= m_wd[g][8*i +: 8];
        end else begin
          m_rd[g] <= ram[m_addr[g]];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic string tg(input string s, input int d);
    return $sformatf("%s_d%0d", s, d);
  endfunction

  // Per-cycle monitor: reset outputs, read returns against the scoreboard, RAM drive.
  task automatic mon(input int d);
    exp_t        e;
    logic        has, ga, gb;
    logic [10:0] ad;
    e   = '0;
    has = 1'b0;
    if (reset) begin
      chk(tg("rst_await", d), 32'(a_wait[d]), 32'd1);
      chk(tg("rst_bwait", d), 32'(b_wait[d]), 32'd1);
      chk(tg("rst_ardv", d), 32'(a_rdv[d]), 32'd0);
      chk(tg("rst_brdv", d), 32'(b_rdv[d]), 32'd0);
      chk(tg("rst_cs", d), 32'(m_cs[d]), 32'd0);
      chk(tg("rst_we", d), 32'(m_we[d]), 32'd0);
      chk(tg("rst_clken", d), 32'(m_ck[d]), 32'd0);
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    chk(tg("clken", d), 32'(m_ck[d]), 32'd1);
    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); has = 1'b1; end
    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); has = 1'b1; end
    chk(tg("a_rdv", d), 32'(a_rdv[d]), 32'(has && !e.m));
    chk(tg("b_rdv", d), 32'(b_rdv[d]), 32'(has && e.m));
    chk(tg("a_rdata", d), a_rd[d], (has && !e.m) ? e.d : 32'd0);
    chk(tg("b_rdata", d), b_rd[d], (has && e.m) ? e.d : 32'd0);
    if (!(a_read || a_write)) chk(tg("a_idle_wait", d), 32'(a_wait[d]), 32'd0);
    if (!(b_read || b_write)) chk(tg("b_idle_wait", d), 32'(b_wait[d]), 32'd0);
    ga = (a_read | a_write) & ~a_wait[d];
    gb = (b_read | b_write) & ~b_wait[d];
    chk(tg("cs", d), 32'(m_cs[d]), 32'(ga | gb));
    if (ga || gb) begin
      ad = ga ? a_address : b_address;
      chk(tg("maddr", d), 32'(m_addr[d]), 32'(ad));
      chk(tg("mbe", d), 32'(m_be[d]), 32'(ga ? a_byteenable : b_byteenable));
      chk(tg("mwd", d), m_wd[d], ga ? a_writedata : b_writedata);
      chk(tg("mwe", d), 32'(m_we[d]), 32'(ga ? a_write : b_write));
      if (ga ? a_write : b_write) begin
        for (int i = 0; i < 4; i++)
          if ((ga ? a_byteenable[i] : b_byteenable[i]))
            shadow[d][ad][8*i +: 8] = ga ? a_writedata[8*i +: 8] : b_writedata[8*i +: 8];
      end else begin
        e.m = gb;
        e.d = shadow[d][ad];
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end else begin
      chk(tg("maddr_idle", d), 32'(m_addr[d]), 32'd0);
      chk(tg("mbe_idle", d), 32'(m_be[d]), 32'd0);
      chk(tg("mwd_idle", d), m_wd[d], 32'd0);
      chk(tg("mwe_idle", d), 32'(m_we[d]), 32'd0);
    end
  endtask

  // Sample away from the active edge.
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic set_a(input logic rd, input logic wr, input logic [10:0] ad,
                       input logic [3:0] be, input logic [31:0] wd);
    a_read = rd; a_write = wr; a_address = ad; a_byteenable = be; a_writedata = wd;
  endtask

  task automatic set_b(input logic rd, input logic wr, input logic [10:0] ad,
                       input logic [3:0] be, input logic [31:0] wd);
    b_read = rd; b_write = wr; b_address = ad; b_byteenable = be; b_writedata = wd;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  // One cycle with the expected grant of each instance; inputs change just after posedge.
  task automatic step(input logic [1:0] exp_rr, input logic [1:0] exp_fp);
    @(negedge clk);
    chk("grant_rr", 32'({(b_read | b_write) & ~b_wait[0], (a_read | a_write) & ~a_wait[0]}), 32'(exp_rr));
    chk("grant_fp", 32'({(b_read | b_write) & ~b_wait[1], (a_read | a_write) & ~a_wait[1]}), 32'(exp_fp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] rr6 [6];
    logic [1:0] fp6 [6];
    logic [1:0] rr8 [8];
    logic [1:0] fp8 [8];
    rr6 = '{GA, GB, GA, GB, GA, GB};
    fp6 = '{GA, GA, GA, GB, GA, GA};
    rr8 = '{GB, GA, GB, GA, GB, GA, GB, GA};
    fp8 = '{GA, GA, GA, GB, GA, GA, GA, GB};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2048; i++) shadow[d][i] = '0;
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single master write then read.
    set_a(1'b0, 1'b1, 11'd5, 4'hF, 32'hDEADBEEF);
    step(GA, GA);
    set_a(1'b1, 1'b0, 11'd5, 4'hF, 32'h0);
    step(GA, GA);
    idle();
    @(negedge clk);
    chk("t1_rdata", a_rd[0], 32'hDEADBEEF);
    chk("t1_rdv", 32'(a_rdv[0]), 32'd1);
    @(posedge clk); #1;

    // Contention with continuous reads.
    set_a(1'b0, 1'b1, 11'd1, 4'hF, 32'h1111_0001);
    step(GA, GA);
    idle();
    set_b(1'b0, 1'b1, 11'd2, 4'hF, 32'h2222_0002);
    step(GB, GB);
    set_a(1'b1, 1'b0, 11'd1, 4'hF, 32'h0);
    set_b(1'b1, 1'b0, 11'd2, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) step(rr6[i], fp6[i]);
    idle();
    step(GN, GN);

    // Byte enables over an all-ones word.
    set_b(1'b0, 1'b1, 11'd7, 4'hF, 32'hFFFFFFFF);
    step(GB, GB);
    set_b(1'b0, 1'b1, 11'd7, 4'b0101, 32'h11223344);
    step(GB, GB);
    idle();
    set_a(1'b1, 1'b0, 11'd7, 4'hF, 32'h0);
    step(GA, GA);
    idle();
    @(negedge clk);
    chk("t3_be_rr", a_rd[0], 32'hFF22FF44);
    chk("t3_be_fp", a_rd[1], 32'hFF22FF44);
    @(posedge clk); #1;

    // Starvation guard vs round-robin under continuous contention.
    set_a(1'b1, 1'b0, 11'd1, 4'hF, 32'h0);
    set_b(1'b1, 1'b0, 11'd2, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) step(rr8[i], fp8[i]);
    idle();
    step(GN, GN);

    // Read and write together is a write with no return beat.
    set_a(1'b1, 1'b1, 11'd3, 4'hF, 32'h5A5A5A5A);
    step(GA, GA);
    idle();
    @(negedge clk);
    chk("t5_nordv", 32'(a_rdv), 32'd0);
    @(posedge clk); #1;
    set_a(1'b1, 1'b0, 11'd3, 4'hF, 32'h0);
    step(GA, GA);
    idle();
    @(negedge clk);
    chk("t5_wdata", a_rd[0], 32'h5A5A5A5A);
    @(posedge clk); #1;

    // Reset while a read is in flight.
    set_a(1'b1, 1'b0, 11'd5, 4'hF, 32'h0);
    step(GA, GA);
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rdv_rst", 32'(a_rdv), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rdv_after", 32'(a_rdv), 32'd0);
    @(posedge clk); #1;
    set_a(1'b1, 1'b0, 11'd1, 4'hF, 32'h0);
    set_b(1'b1, 1'b0, 11'd2, 4'hF, 32'h0);
    step(GA, GA);
    step(GB, GA);
    idle();
    step(GN, GN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
